// File: rtl/input_debouncer.sv
// Multi-channel input conditioner: synchroniser, saturating integrator and hysteretic level/edge outputs.
// Optional LONG_PRESS_EN macro adds per-channel hold counters driving long_press.
module input_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 4,
    parameter int THRESH      = 15,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_W      = 16,
    parameter int LONG_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press
);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_d  [CHANNELS];
    logic [CNT_W-1:0]       cnt_q   [CHANNELS];
    logic [CNT_W-1:0]       cnt_d   [CHANNELS];
    state_e                 state_q [CHANNELS];
    state_e                 state_d [CHANNELS];
    logic [CHANNELS-1:0]    rise_q, rise_d;
    logic [CHANNELS-1:0]    fall_q, fall_d;
    logic [CHANNELS-1:0]    din_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_LOW;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Synchroniser shift and saturating up/down integrator
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], din[i]};
            din_s[i]  = sync_q[i][SYNC_STAGES-1];
            cnt_d[i]  = cnt_q[i];
            if (din_s[i] && (cnt_q[i] < THR)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!din_s[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Hysteresis decided on the next count so the edge pulse lines up with the level change
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            case (state_q[i])
                ST_LOW: begin
                    if (cnt_d[i] == THR) begin
                        state_d[i] = ST_HIGH;
                        rise_d[i]  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_d[i] == '0) begin
                        state_d[i] = ST_LOW;
                        fall_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = ST_LOW;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            dout[i] = (state_q[i] == ST_HIGH);
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LC     = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LC_M1  = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0]   hold_q [CHANNELS];
    logic [LONG_W-1:0]   hold_d [CHANNELS];
    logic [CHANNELS-1:0] long_press_q, long_press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
            long_press_q <= '0;
        end else begin
            hold_q       <= hold_d;
            long_press_q <= long_press_d;
        end
    end

    // Hold saturates at LC, so the LC-1 -> LC step happens only once per press
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hold_d[i]       = '0;
            long_press_d[i] = 1'b0;
            if (state_q[i] == ST_HIGH) begin
                hold_d[i]       = (hold_q[i] == LC) ? hold_q[i] : hold_q[i] + LONG_W'(1);
                long_press_d[i] = (hold_q[i] == LC_M1);
            end
        end
    end

    assign long_press = long_press_q;
`else
    // Feature absent: port kept constant; parameters still referenced for a uniform interface
    assign long_press = {CHANNELS{1'b0}} & {CHANNELS{(LONG_W > 0) && (LONG_CYCLES > 0)}};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus randomized traffic against a per-channel reference model.
module tb_input_debouncer;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int TH   = 15;
    localparam int SS   = 2;
    localparam int LW   = 16;
    localparam int LONG = 100;
    localparam int LAT  = SS + TH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] dout, rise, fall, long_press;

    int n_checks = 0;
    int n_errors = 0;

    input_debouncer #(
        .CHANNELS(CH), .CNT_W(CW), .THRESH(TH), .SYNC_STAGES(SS),
        .LONG_W(LW), .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Reference: the integrator sees din as sampled SS edges earlier
    typedef struct {
        int cnt;
        bit lvl;
        bit rs;
        bit fl;
        int hold;
        bit lp;
    } ch_t;

    ch_t           mdl [CH];
    logic [CH-1:0] samp_q [$];

    function automatic bit delayed_bit(int i);
        logic [CH-1:0] v;
        if (samp_q.size() < SS) return 1'b0;
        v = samp_q[samp_q.size() - SS];
        return v[i];
    endfunction

    function automatic ch_t step(ch_t c, bit s);
        ch_t n;
        n = c;
        n.rs = 1'b0;
        n.fl = 1'b0;
        n.lp = 1'b0;
        if (s) n.cnt = (c.cnt < TH) ? c.cnt + 1 : c.cnt;
        else   n.cnt = (c.cnt > 0) ? c.cnt - 1 : 0;
        if (!c.lvl && n.cnt == TH) begin
            n.lvl = 1'b1;
            n.rs  = 1'b1;
        end else if (c.lvl && n.cnt == 0) begin
            n.lvl = 1'b0;
            n.fl  = 1'b1;
        end
`ifdef LONG_PRESS_EN
        if (c.lvl) begin
            n.hold = (c.hold < LONG) ? c.hold + 1 : c.hold;
            n.lp   = (c.hold == LONG - 1);
        end else begin
            n.hold = 0;
        end
`endif
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q.delete();
            for (int i = 0; i < CH; i++) mdl[i] <= '{default: 0};
        end else begin
            for (int i = 0; i < CH; i++) mdl[i] <= step(mdl[i], delayed_bit(i));
            samp_q.push_back(din);
            if (samp_q.size() > SS + 1) void'(samp_q.pop_front());
        end
    end

    function automatic logic [4*CH-1:0] model_out();
        logic [CH-1:0] d, r, f, l;
        for (int i = 0; i < CH; i++) begin
            d[i] = mdl[i].lvl;
            r[i] = mdl[i].rs;
            f[i] = mdl[i].fl;
            l[i] = mdl[i].lp;
        end
        return {d, r, f, l};
    endfunction

    task automatic idle(int n);
        din = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dout, rise, fall, long_press} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h want=0", {dout, rise, fall, long_press});
        end
        din = '0;
        rst = 1'b0;
        idle(3);
        n_checks++;
        if ({dout, rise, fall, long_press} !== '0) begin
            n_errors++;
            $display("FAIL post_reset_idle got=%h want=0", {dout, rise, fall, long_press});
        end
    endtask

    task automatic test_rise_latency();
        int first = -1;
        int nrise = 0;
        int other = 0;
        din = '0;
        din[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t1_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[0]) begin
                nrise++;
                if (first < 0) first = k;
            end
            if ((dout[CH-1:1] | rise[CH-1:1] | fall[CH-1:1]) != '0) other++;
        end
        n_checks++;
        if (first !== LAT) begin
            n_errors++;
            $display("FAIL t1_rise_edge got=%0d want=%0d", first, LAT);
        end
        n_checks++;
        if (nrise !== 1) begin
            n_errors++;
            $display("FAIL t1_rise_count got=%0d want=1", nrise);
        end
        n_checks++;
        if (dout[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL t1_dout got=%b want=1", dout[0]);
        end
        n_checks++;
        if (other !== 0) begin
            n_errors++;
            $display("FAIL t1_other_channels got=%0d want=0", other);
        end
        idle(40);
    endtask

    task automatic test_bounce();
        int bounce_edges = 0;
        int nrise = 0;
        int nfall = 0;
        for (int k = 0; k < 60; k++) begin
            din[1] = ((k / 3) % 2 == 0);
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t2_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[1] || fall[1] || dout[1]) bounce_edges++;
        end
        din[1] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t2_model_hold k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[1]) nrise++;
            if (fall[1]) nfall++;
        end
        n_checks++;
        if (bounce_edges !== 0) begin
            n_errors++;
            $display("FAIL t2_bounce_activity got=%0d want=0", bounce_edges);
        end
        n_checks++;
        if (nrise !== 1 || nfall !== 0) begin
            n_errors++;
            $display("FAIL t2_stable_edges rise=%0d fall=%0d want rise=1 fall=0", nrise, nfall);
        end
        idle(40);
    endtask

    task automatic test_hysteresis();
        int nfall = 0;
        int lowcnt = 0;
        int fall_at = -1;
        din[2] = 1'b1;
        repeat (30) @(negedge clk);
        din[2] = 1'b0;
        for (int k = 0; k < 35; k++) begin
            if (k == 10) din[2] = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t3_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (fall[2]) nfall++;
            if (!dout[2]) lowcnt++;
        end
        n_checks++;
        if (nfall !== 0 || lowcnt !== 0) begin
            n_errors++;
            $display("FAIL t3_glitch_hold falls=%0d low_cycles=%0d want 0 0", nfall, lowcnt);
        end
        din[2] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (fall[2] && fall_at < 0) fall_at = k;
        end
        n_checks++;
        if (fall_at !== LAT || dout[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL t3_fall_edge got=%0d dout=%b want=%0d dout=0", fall_at, dout[2], LAT);
        end
        idle(10);
    endtask

    task automatic test_saturation();
        int nrise = 0;
        int nfall = 0;
        int fall_at = -1;
        din[3] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t4_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[3]) nrise++;
            if (fall[3]) nfall++;
        end
        n_checks++;
        if (nrise !== 1 || nfall !== 0) begin
            n_errors++;
            $display("FAIL t4_edges rise=%0d fall=%0d want 1 0", nrise, nfall);
        end
        din[3] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (fall[3] && fall_at < 0) fall_at = k;
        end
        n_checks++;
        if (fall_at !== LAT) begin
            n_errors++;
            $display("FAIL t4_release_edge got=%0d want=%0d", fall_at, LAT);
        end
        idle(10);
    endtask

    task automatic test_reset_mid();
        int rise_at = -1;
        din = '0;
        din[1] = 1'b1;
        repeat (20) @(negedge clk);
        din[0] = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (dout[1] !== 1'b1 || dout[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL t5_pre_reset dout=%b want 0010", dout);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dout, rise, fall, long_press} !== '0) begin
            n_errors++;
            $display("FAIL t5_async_clear got=%h want=0", {dout, rise, fall, long_press});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t5_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[0] && rise_at < 0) rise_at = k;
        end
        n_checks++;
        if (rise_at !== LAT) begin
            n_errors++;
            $display("FAIL t5_rise_after_reset got=%0d want=%0d", rise_at, LAT);
        end
        idle(40);
    endtask

    task automatic test_long_press();
        int rise_at = -1;
        int lp_at = -1;
        int nlp = 0;
        din[0] = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL t6_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            if (rise[0] && rise_at < 0) rise_at = k;
            if (long_press != '0) begin
                nlp++;
                if (lp_at < 0) lp_at = k;
            end
        end
`ifdef LONG_PRESS_EN
        n_checks++;
        if (nlp !== 1 || (lp_at - rise_at) !== LONG) begin
            n_errors++;
            $display("FAIL t6_long_press count=%0d delay=%0d want count=1 delay=%0d", nlp, lp_at - rise_at, LONG);
        end
`else
        n_checks++;
        if (nlp !== 0) begin
            n_errors++;
            $display("FAIL t6_long_press_disabled count=%0d want=0", nlp);
        end
`endif
        idle(40);
    endtask

    task automatic test_random();
        int left [CH];
        for (int i = 0; i < CH; i++) left[i] = $urandom_range(1, 30);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    din[i] = ~din[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end
            end
            if ($urandom_range(0, 799) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if ({dout, rise, fall, long_press} !== model_out()) begin
                n_errors++;
                $display("FAIL rand_model k=%0d got=%h want=%h", k, {dout, rise, fall, long_press}, model_out());
            end
            n_checks++;
            if ((rise & fall) != '0) begin
                n_errors++;
                $display("FAIL rand_rise_fall_overlap k=%0d rise=%b fall=%b want disjoint", k, rise, fall);
            end
        end
        idle(40);
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_bounce();
        test_hysteresis();
        test_saturation();
        test_reset_mid();
        test_long_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
